clock_monitor: RTL

- Sits directly downstream of the behavioural clock generator. Measures the generated clock `mon_clk` in the synchronous reference domain `clk`.
- Reports period and high-time sums over a window of NUM_PERIODS rising edges, plus a range check and loss-of-clock detection.
- Gives self-checking benches, and later on-chip logic, a synthesizable check of FREQ/DUTY instead of reading a waveform dump.

---
 rtl/clock_monitor_if.sv | 24 ++
 rtl/clock_monitor.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/clock_monitor_if.sv
// Reference-domain control and result bundle of clock_monitor.
// The bench or host drives the master side; the monitor implements the slave side.
interface clock_monitor_if #(
    parameter int CNT_W = 16
);
    logic             enable;
    logic             clear_lost;
    logic [CNT_W-1:0] period_sum;
    logic [CNT_W-1:0] high_sum;
    logic             result_valid;
    logic             in_range;
    logic             clk_present;
    logic             clk_lost;

    modport master (
        output enable, clear_lost,
        input  period_sum, high_sum, result_valid, in_range, clk_present, clk_lost
    );

    modport slave (
        input  enable, clear_lost,
        output period_sum, high_sum, result_valid, in_range, clk_present, clk_lost
    );
endinterface

// File: rtl/clock_monitor.sv
// Measures period and high time of mon_clk over NUM_PERIODS rises in the clk domain,
// with a range check on the period sum and a loss-of-clock timeout.
//   state   | meaning
//   IDLE    | monitor disabled, counters cleared
//   ARM     | waiting for the first rise of a window
//   MEASURE | window open, counting cycles, high cycles and rises
module clock_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int NUM_PERIODS = 8,
    parameter int TIMEOUT     = 1024,
    parameter int PERIOD_MIN  = 24,
    parameter int PERIOD_MAX  = 40
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mon_clk,
    clock_monitor_if.slave bus
);
    localparam int EDGE_W = $clog2(NUM_PERIODS) + 1;
    localparam int TO_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(NUM_PERIODS - 1);
    localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s, s_prev, rise;
    logic [CNT_W-1:0]       period_cnt, high_cnt;
    logic [EDGE_W-1:0]      edge_cnt;
    logic                   sat_q;
    logic [TO_W-1:0]        to_cnt;
    logic                   start_win, complete, measuring, fire;

    logic [CNT_W-1:0]       period_sum_q, high_sum_q;
    logic                   result_valid_q, in_range_q, clk_present_q, clk_lost_q;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_prev <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], mon_clk};
            s_prev <= s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A completing rise both closes the window and opens the next one.
    always_comb begin
        state_d   = state_q;
        start_win = 1'b0;
        complete  = 1'b0;
        measuring = 1'b0;
        fire      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.enable) state_d = ARM;
            end
            ARM: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (rise) begin
                    start_win = 1'b1;
                    state_d   = MEASURE;
                end else if (to_cnt == TO_ONE) begin
                    fire = 1'b1;
                end
            end
            MEASURE: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (rise && edge_cnt == LAST_EDGE) begin
                    complete  = 1'b1;
                    start_win = 1'b1;
                end else if (!rise && to_cnt == TO_ONE) begin
                    fire    = 1'b1;
                    state_d = ARM;
                end else begin
                    measuring = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
            high_cnt   <= '0;
            edge_cnt   <= '0;
            sat_q      <= 1'b0;
        end else if (start_win) begin
            period_cnt <= CNT_W'(1);
            high_cnt   <= CNT_W'(s);
            edge_cnt   <= '0;
            sat_q      <= 1'b0;
        end else if (measuring) begin
            if (period_cnt == CNT_MAX) sat_q <= 1'b1;
            else                       period_cnt <= period_cnt + CNT_W'(1);
            if (s) begin
                if (high_cnt == CNT_MAX) sat_q <= 1'b1;
                else                     high_cnt <= high_cnt + CNT_W'(1);
            end
            if (rise) edge_cnt <= edge_cnt + EDGE_W'(1);
        end else begin
            period_cnt <= '0;
            high_cnt   <= '0;
            edge_cnt   <= '0;
            sat_q      <= 1'b0;
        end
    end

    // Down-counter reloaded on every rise; terminal count 1 means TIMEOUT cycles elapsed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state_q == IDLE || !bus.enable || rise || fire) begin
            to_cnt <= TO_LOAD;
        end else if (to_cnt != '0) begin
            to_cnt <= to_cnt - TO_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_sum_q   <= '0;
            high_sum_q     <= '0;
            result_valid_q <= 1'b0;
            in_range_q     <= 1'b0;
            clk_present_q  <= 1'b0;
            clk_lost_q     <= 1'b0;
        end else begin
            result_valid_q <= complete;
            if (complete) begin
                period_sum_q <= period_cnt;
                high_sum_q   <= high_cnt;
                in_range_q   <= !sat_q && (int'(period_cnt) >= PERIOD_MIN)
                                       && (int'(period_cnt) <= PERIOD_MAX);
            end
            if (!bus.enable || fire)         clk_present_q <= 1'b0;
            else if (rise && state_q != IDLE) clk_present_q <= 1'b1;
            if (fire)                clk_lost_q <= 1'b1;
            else if (bus.clear_lost) clk_lost_q <= 1'b0;
        end
    end

    assign bus.period_sum   = period_sum_q;
    assign bus.high_sum     = high_sum_q;
    assign bus.result_valid = result_valid_q;
    assign bus.in_range     = in_range_q;
    assign bus.clk_present  = clk_present_q;
    assign bus.clk_lost     = clk_lost_q;
endmodule
